ir_nec_rx_ctrl: RTL

- Receive controller/sequencer for the IR remote path.
- Samples the demodulated IR receiver output, times marks and spaces with a prescaled tick counter, and sequences leader → 32 data bits → validation.
- Reports a completed frame (done/error/repeat pulses, address/command bytes) to the top-level IR state machine that consumes its DONE/ERROR indications.

---
 rtl/ir_pkg.sv | 27 ++
 rtl/ir_sync_edge.sv | 36 +++
 rtl/ir_nec_rx_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR receive path: FSM state type and
// default protocol timing expressed in 10 us ticks.
package ir_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARMED,
    S_LDR_MARK,
    S_LDR_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_CHECK,
    S_DONE,
    S_ERR
  } ir_state_t;

  localparam int unsigned NEC_TICK_DIV       = 500;
  localparam int unsigned NEC_CNT_W          = 11;
  localparam int unsigned NEC_LDR_MARK_MIN   = 800;
  localparam int unsigned NEC_LDR_SPACE_MIN  = 400;
  localparam int unsigned NEC_RPT_SPACE_MIN  = 180;
  localparam int unsigned NEC_BIT_MARK_MAX   = 100;
  localparam int unsigned NEC_BIT_ONE_THRESH = 112;
  localparam int unsigned NEC_TIMEOUT        = 1200;
  localparam int unsigned NEC_BITS           = 32;

endpackage

// File: rtl/ir_sync_edge.sv
// Two-flop synchronizer for the asynchronous IR receiver output with
// rise/fall pulses on the synchronized level; resets to the idle-high line.
module ir_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/ir_nec_rx_ctrl.sv
// NEC IR receive sequencer: times marks/spaces in prescaled ticks, decodes
// leader, 32 data bits or a repeat code, and reports one done/error pulse.
module ir_nec_rx_ctrl
  import ir_pkg::*;
#(
  parameter int unsigned TICK_DIV       = NEC_TICK_DIV,
  parameter int unsigned CNT_W          = NEC_CNT_W,
  parameter int unsigned LDR_MARK_MIN   = NEC_LDR_MARK_MIN,
  parameter int unsigned LDR_SPACE_MIN  = NEC_LDR_SPACE_MIN,
  parameter int unsigned RPT_SPACE_MIN  = NEC_RPT_SPACE_MIN,
  parameter int unsigned BIT_MARK_MAX   = NEC_BIT_MARK_MAX,
  parameter int unsigned BIT_ONE_THRESH = NEC_BIT_ONE_THRESH,
  parameter int unsigned TIMEOUT        = NEC_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ir_in,
  input  logic       read,
  output logic       busy,
  output logic       done,
  output logic       repeat_o,
  output logic       error,
  output logic [7:0] addr,
  output logic [7:0] cmd
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LDR_MARK_C  = CNT_W'(LDR_MARK_MIN);
  localparam logic [CNT_W-1:0] LDR_SPACE_C = CNT_W'(LDR_SPACE_MIN);
  localparam logic [CNT_W-1:0] RPT_SPACE_C = CNT_W'(RPT_SPACE_MIN);
  localparam logic [CNT_W-1:0] BIT_MARK_C  = CNT_W'(BIT_MARK_MAX);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(BIT_ONE_THRESH);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [4:0]       LAST_BIT    = 5'(NEC_BITS - 1);

  logic rise, fall, tick, timed_out;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  ir_state_t           state_q, state_d;
  logic [4:0]          bit_idx_q, bit_idx_d;
  logic [NEC_BITS-1:0] sr_q, sr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rpt_q, rpt_d;
  logic                err_q, err_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          cmd_q, cmd_d;

  // Line is idle high; a falling synchronized edge is the start of a mark.
  ir_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ir_in),
    .rise  (rise),
    .fall  (fall)
  );

  assign tick      = (pre_q == PRE_LAST);
  assign timed_out = (cnt_q >= TIMEOUT_C);

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    if (rise || fall)
      cnt_d = '0;
    else if (tick && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    sr_d      = sr_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    rpt_d     = 1'b0;
    // Decisions use the count of the phase that is ending; the counter clears on the same edge.
    case (state_q)
      S_IDLE:  if (read) state_d = S_ARMED;
      S_ARMED: if (fall) state_d = S_LDR_MARK;
      S_LDR_MARK: begin
        if (timed_out)  state_d = S_ERR;
        else if (rise)  state_d = (cnt_q >= LDR_MARK_C) ? S_LDR_SPACE : S_ARMED;
      end
      S_LDR_SPACE: begin
        if (timed_out) begin
          state_d = S_ERR;
        end else if (fall) begin
          if (cnt_q >= LDR_SPACE_C) begin
            state_d   = S_BIT_MARK;
            bit_idx_d = '0;
          end else if (cnt_q >= RPT_SPACE_C) begin
            state_d = S_DONE;
            rpt_d   = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_BIT_MARK: begin
        if (timed_out)  state_d = S_ERR;
        else if (rise)  state_d = (cnt_q <= BIT_MARK_C) ? S_BIT_SPACE : S_ERR;
      end
      S_BIT_SPACE: begin
        if (timed_out) begin
          state_d = S_ERR;
        end else if (fall) begin
          sr_d = {(cnt_q >= ONE_C), sr_q[NEC_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d = S_CHECK;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = S_BIT_MARK;
          end
        end
      end
      S_CHECK: begin
        if ((sr_q[15:8] == ~sr_q[7:0]) && (sr_q[31:24] == ~sr_q[23:16])) begin
          addr_d  = sr_q[7:0];
          cmd_d   = sr_q[23:16];
          state_d = S_DONE;
        end else begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERR});
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      bit_idx_q <= '0;
      sr_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rpt_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      cmd_q     <= '0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      sr_q      <= sr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rpt_q     <= rpt_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign repeat_o = rpt_q;
  assign error    = err_q;
  assign addr     = addr_q;
  assign cmd      = cmd_q;

endmodule
